// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer.
// Counter encodings, flush FSM states and the saturating counter step.
package btb_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } btb_state_e;

  // Saturating 2-bit direction counter step.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/btb_flush_ctrl.sv
// Flush sequencer for the BTB: walks the table one entry per cycle,
// raising busy for exactly ENTRIES cycles. A new flush restarts the walk.
module btb_flush_ctrl
  import btb_pkg::*;
#(
  parameter int ENTRIES = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  output logic                       busy,
  output logic [$clog2(ENTRIES)-1:0] clr_idx
);
  localparam int IDX = $clog2(ENTRIES);

  btb_state_e     state_q, state_d;
  logic [IDX-1:0] idx_q, idx_d;

  // State and sweep index registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: enter or restart the sweep on flush, leave after the last index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        busy = 1'b1;
        if (flush) begin
          idx_d = '0;
        end else if (idx_q == IDX'(ENTRIES - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign clr_idx = idx_q;

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with a one-deep registered update stage.
// Lookup is combinational and forwards the pending update on an index match.
// Optional feature macro: BTB_DIR_COUNTER_EN (2-bit direction counters per entry);
// without it a hit simply predicts taken and a not-taken hit evicts the entry.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pred_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            flush,
  output logic            busy
);
  localparam int IDX = $clog2(ENTRIES);
  localparam int TAG = XLEN - IDX - 2;

  logic [ENTRIES-1:0]           valid_q, valid_d;
  logic [ENTRIES-1:0][TAG-1:0]  tag_q, tag_d;
  logic [ENTRIES-1:0][XLEN-1:0] tgt_q, tgt_d;
`ifdef BTB_DIR_COUNTER_EN
  logic [ENTRIES-1:0][1:0]      ctr_q, ctr_d;
  logic [1:0]                   nw_ctr, e_ctr;
`endif

  logic            pend_vld_q, pend_vld_d;
  logic [IDX-1:0]  pend_idx_q, pend_idx_d;
  logic [TAG-1:0]  pend_tag_q, pend_tag_d;
  logic            pend_tkn_q, pend_tkn_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;

  logic            rd_hit, nw_valid;
  logic [TAG-1:0]  nw_tag;
  logic [XLEN-1:0] nw_tgt;

  logic [IDX-1:0]  lk_idx;
  logic [TAG-1:0]  lk_tag, e_tag;
  logic            fwd, e_valid;
  logic [XLEN-1:0] e_tgt;
  logic [IDX-1:0]  clr_idx;

  // Word-alignment bits of both PCs carry no information here.
  logic unused_bits;
  assign unused_bits = ^{pc[1:0], upd_pc[1:0]};

  btb_flush_ctrl #(.ENTRIES(ENTRIES)) u_flush (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .busy   (busy),
    .clr_idx(clr_idx)
  );

  // Entry as it will look once the pending update is committed.
  always_comb begin
    rd_hit   = valid_q[pend_idx_q] && (tag_q[pend_idx_q] == pend_tag_q);
    nw_valid = valid_q[pend_idx_q];
    nw_tag   = tag_q[pend_idx_q];
    nw_tgt   = tgt_q[pend_idx_q];
`ifdef BTB_DIR_COUNTER_EN
    nw_ctr   = ctr_q[pend_idx_q];
    if (rd_hit) begin
      nw_ctr = ctr_next(ctr_q[pend_idx_q], pend_tkn_q);
      if (pend_tkn_q) nw_tgt = pend_tgt_q;
    end else if (pend_tkn_q) begin
      nw_valid = 1'b1;
      nw_tag   = pend_tag_q;
      nw_tgt   = pend_tgt_q;
      nw_ctr   = CTR_WT;
    end
`else
    if (pend_tkn_q) begin
      nw_valid = 1'b1;
      nw_tag   = pend_tag_q;
      nw_tgt   = pend_tgt_q;
    end else if (rd_hit) begin
      nw_valid = 1'b0;
    end
`endif
  end

  // Lookup with forwarding from the pending update; a sweep forces a miss.
  always_comb begin
    lk_idx  = pc[IDX+1:2];
    lk_tag  = pc[XLEN-1:IDX+2];
    fwd     = pend_vld_q && (pend_idx_q == lk_idx);
    e_valid = fwd ? nw_valid : valid_q[lk_idx];
    e_tag   = fwd ? nw_tag   : tag_q[lk_idx];
    e_tgt   = fwd ? nw_tgt   : tgt_q[lk_idx];
    pred_hit = !busy && e_valid && (e_tag == lk_tag);
`ifdef BTB_DIR_COUNTER_EN
    e_ctr      = fwd ? nw_ctr : ctr_q[lk_idx];
    pred_taken = pred_hit && e_ctr[1];
`else
    pred_taken = pred_hit;
`endif
    pred_pc = pred_taken ? e_tgt : pc + XLEN'(4);
  end

  // Capture a resolved branch unless flushing or sweeping; flush drops it.
  always_comb begin
    pend_vld_d = 1'b0;
    pend_idx_d = pend_idx_q;
    pend_tag_d = pend_tag_q;
    pend_tkn_d = pend_tkn_q;
    pend_tgt_d = pend_tgt_q;
    if (upd_valid && !flush && !busy) begin
      pend_vld_d = 1'b1;
      pend_idx_d = upd_pc[IDX+1:2];
      pend_tag_d = upd_pc[XLEN-1:IDX+2];
      pend_tkn_d = upd_taken;
      pend_tgt_d = upd_target;
    end
  end

  // Pending update register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_vld_q <= 1'b0;
      pend_idx_q <= '0;
      pend_tag_q <= '0;
      pend_tkn_q <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_idx_q <= pend_idx_d;
      pend_tag_q <= pend_tag_d;
      pend_tkn_q <= pend_tkn_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  // Table next state: sweep clears one valid bit, otherwise commit the pending update.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
`ifdef BTB_DIR_COUNTER_EN
    ctr_d   = ctr_q;
`endif
    if (busy) begin
      valid_d[clr_idx] = 1'b0;
    end else if (pend_vld_q && !flush) begin
      valid_d[pend_idx_q] = nw_valid;
      tag_d[pend_idx_q]   = nw_tag;
      tgt_d[pend_idx_q]   = nw_tgt;
`ifdef BTB_DIR_COUNTER_EN
      ctr_d[pend_idx_q]   = nw_ctr;
`endif
    end
  end

  // Table storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      tag_q   <= '0;
      tgt_q   <= '0;
`ifdef BTB_DIR_COUNTER_EN
      ctr_q   <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
`ifdef BTB_DIR_COUNTER_EN
      ctr_q   <= ctr_d;
`endif
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed scenarios with literal
// expectations plus a randomized phase checked every cycle against a model
// that applies each accepted update immediately and treats a flush as an
// instant wipe followed by ENTRIES busy cycles.
module tb_btb_predictor;
  localparam int ENTRIES = 32;
  localparam int XLEN    = 32;
  localparam int IDX     = $clog2(ENTRIES);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [XLEN-1:0] pc = '0;
  logic [XLEN-1:0] pred_pc;
  logic            pred_hit, pred_taken;
  logic            upd_valid = 1'b0;
  logic [XLEN-1:0] upd_pc = '0;
  logic            upd_taken = 1'b0;
  logic [XLEN-1:0] upd_target = '0;
  logic            flush = 1'b0;
  logic            busy;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  btb_predictor #(.ENTRIES(ENTRIES), .XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .pred_pc   (pred_pc),
    .pred_hit  (pred_hit),
    .pred_taken(pred_taken),
    .upd_valid (upd_valid),
    .upd_pc    (upd_pc),
    .upd_taken (upd_taken),
    .upd_target(upd_target),
    .flush     (flush),
    .busy      (busy)
  );

  // ---------------- reference model ----------------
  bit              m_valid [ENTRIES];
  logic [XLEN-1:0] m_tag   [ENTRIES];
  logic [XLEN-1:0] m_tgt   [ENTRIES];
  int              m_ctr   [ENTRIES];
  int              m_busy;

  function automatic int idx_of(input logic [XLEN-1:0] p);
    return int'((p >> 2) % ENTRIES);
  endfunction

  function automatic logic [XLEN-1:0] tag_of(input logic [XLEN-1:0] p);
    return p >> (IDX + 2);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
      end
      m_busy = 0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      m_busy = ENTRIES;
    end else if (m_busy > 0) begin
      m_busy = m_busy - 1;
    end else if (upd_valid) begin
      int  i;
      bit  h;
      i = idx_of(upd_pc);
      h = m_valid[i] && (m_tag[i] == tag_of(upd_pc));
`ifdef BTB_DIR_COUNTER_EN
      if (h) begin
        if (upd_taken) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (upd_taken) begin
        m_valid[i] = 1'b1; m_tag[i] = tag_of(upd_pc); m_tgt[i] = upd_target; m_ctr[i] = 2;
      end
`else
      if (upd_taken) begin
        m_valid[i] = 1'b1; m_tag[i] = tag_of(upd_pc); m_tgt[i] = upd_target;
      end else if (h) begin
        m_valid[i] = 1'b0;
      end
`endif
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Every cycle outside reset, compare the DUT outputs against the model.
  always @(negedge clk) begin
    if (reset && chk_on) begin
      int              i;
      bit              eh, et;
      logic [XLEN-1:0] ep;
      i  = idx_of(pc);
      eh = (m_busy == 0) && m_valid[i] && (m_tag[i] == tag_of(pc));
`ifdef BTB_DIR_COUNTER_EN
      et = eh && (m_ctr[i] >= 2);
`else
      et = eh;
`endif
      ep = et ? m_tgt[i] : pc + 32'd4;
      chk("model_busy", busy, (m_busy > 0));
      chk("model_hit", pred_hit, eh);
      chk("model_taken", pred_taken, et);
      chk("model_pred_pc", pred_pc, ep);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic upd(input logic [XLEN-1:0] p, input logic tk, input logic [XLEN-1:0] tg);
    upd_valid = 1'b1; upd_pc = p; upd_taken = tk; upd_target = tg;
    cyc();
    upd_valid = 1'b0;
  endtask

  task automatic look(input string nm, input logic [XLEN-1:0] p,
                      input logic eh, input logic [XLEN-1:0] ep);
    pc = p; #1;
    chk({nm, "_hit"}, pred_hit, eh);
    chk({nm, "_pc"}, pred_pc, ep);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin cyc(); n++; end
    chk("sweep_timeout", busy, 1'b0);
  endtask

  function automatic logic [XLEN-1:0] rpc();
    logic [XLEN-1:0] t, i, lo;
    if ($urandom_range(0, 15) == 0) return XLEN'($urandom);
    t  = XLEN'($urandom_range(0, 2));
    i  = XLEN'($urandom_range(0, ENTRIES - 1));
    lo = XLEN'($urandom_range(0, 3));
    return (t << (IDX + 2)) | (i << 2) | lo;
  endfunction

  initial begin
    int n;
    // Reset takes effect with no clock edge.
    #1 reset = 1'b0;
    pc = 32'h100; #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_hit", pred_hit, 1'b0);
    chk("rst_taken", pred_taken, 1'b0);
    chk("rst_pc", pred_pc, 32'h104);
    pc = 32'hFFFF_FFFC; #1;
    chk("rst_wrap_pc", pred_pc, 32'h0);
    cyc(); cyc();
    reset = 1'b1;
    chk_on = 1'b1;
    cyc();

    // Allocation, forwarding, aliasing index with a different tag.
    look("cold", 32'h100, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h400);
    look("alloc", 32'h100, 1'b1, 32'h400);
    look("alias", 32'h100 + ENTRIES * 4, 1'b0, 32'h184);
    cyc();
    look("commit", 32'h100, 1'b1, 32'h400);

`ifdef BTB_DIR_COUNTER_EN
    // Hysteresis: saturate high, then walk down and saturate low.
    repeat (4) upd(32'h100, 1'b1, 32'h400);
    upd(32'h100, 1'b0, 32'h0);
    look("hyst_nt1", 32'h100, 1'b1, 32'h400);
    upd(32'h100, 1'b0, 32'h0);
    look("hyst_nt2", 32'h100, 1'b1, 32'h104);
    upd(32'h100, 1'b0, 32'h0);
    look("hyst_nt3", 32'h100, 1'b1, 32'h104);
    repeat (4) begin
      upd(32'h100, 1'b0, 32'h0);
      look("hyst_floor", 32'h100, 1'b1, 32'h104);
    end
    upd(32'h100, 1'b1, 32'h400);
    look("hyst_up1", 32'h100, 1'b1, 32'h104);
    upd(32'h100, 1'b1, 32'h400);
    look("hyst_up2", 32'h100, 1'b1, 32'h400);
    // Back-to-back updates stack: alloc(2) then hit(3), one not-taken keeps taken.
    upd_valid = 1'b1; upd_pc = 32'h500; upd_taken = 1'b1; upd_target = 32'h600; cyc();
    upd_target = 32'h700; cyc();
    upd_taken = 1'b0; cyc();
    upd_valid = 1'b0;
    look("b2b", 32'h500, 1'b1, 32'h700);
`else
    // Without counters a not-taken hit evicts the entry.
    upd(32'h140, 1'b1, 32'h440);
    upd(32'h140, 1'b0, 32'h0);
    look("evict", 32'h140, 1'b0, 32'h144);
    upd_valid = 1'b1; upd_pc = 32'h500; upd_taken = 1'b1; upd_target = 32'h600; cyc();
    upd_target = 32'h700; cyc();
    upd_valid = 1'b0;
    look("b2b", 32'h500, 1'b1, 32'h700);
`endif

    // Flush: busy for exactly ENTRIES cycles, update mid-sweep dropped.
    cyc();
    flush = 1'b1; cyc(); flush = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      upd_valid = (n == 5); upd_pc = 32'h200; upd_taken = 1'b1; upd_target = 32'h800;
      cyc();
    end
    upd_valid = 1'b0;
    chk("flush_busy_cycles", 64'(n), 64'(ENTRIES));
    look("post_flush_100", 32'h100, 1'b0, 32'h104);
    look("post_flush_200", 32'h200, 1'b0, 32'h204);

    // Flush and update in the same cycle: update dropped.
    cyc();
    flush = 1'b1; upd_valid = 1'b1; upd_pc = 32'h300; upd_taken = 1'b1; upd_target = 32'habc;
    cyc();
    flush = 1'b0; upd_valid = 1'b0;
    wait_idle();
    look("flush_same_cycle", 32'h300, 1'b0, 32'h304);

    // Pending update discarded by a flush on the following edge.
    upd(32'h340, 1'b1, 32'h990);
    flush = 1'b1;
    look("pend_fwd", 32'h340, 1'b1, 32'h990);
    cyc(); flush = 1'b0;
    wait_idle();
    look("pend_dropped", 32'h340, 1'b0, 32'h344);

    // Randomized phase, checked every cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      cyc();
      pc         = rpc();
      upd_valid  = ($urandom_range(0, 2) != 0);
      upd_pc     = rpc();
      upd_taken  = ($urandom_range(0, 9) < 6);
      upd_target = XLEN'($urandom);
      flush      = ($urandom_range(0, 299) == 0);
    end
    cyc();
    upd_valid = 1'b0; flush = 1'b0;
    wait_idle();

    // Reset in the middle of a sweep.
    upd(32'h100, 1'b1, 32'h400);
    flush = 1'b1; cyc(); flush = 1'b0;
    repeat (10) cyc();
    #1 reset = 1'b0;
    pc = 32'h100; #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_hit", pred_hit, 1'b0);
    chk("midrst_pc", pred_pc, 32'h104);
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    look("after_rst_miss", 32'h100, 1'b0, 32'h104);
    upd(32'h100, 1'b1, 32'h900);
    look("after_rst_train", 32'h100, 1'b1, 32'h900);
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
